disp_signed_dec_seq: RTL and testbench
======================================

// Module: disp_signed_dec_seq
// PURPOSE
//  Sequential binary-to-decimal display driver for 7-segment banks. Converts a WIDTH-bit
//  operand, signed (two's complement) or unsigned, with an iterative shift-add-3 engine
//  (one bit per clock). It drives DIGITS active-low displays with leading-zero blanking,
//  a floating minus sign and overflow indication. It is the generalised successor to the
//  fixed 8-bit, 4-digit combinational decimal display and sits between the calculator
//  datapath and the HEX outputs.
// PARAMETERS
//  WIDTH   8  operand width in bits (>=2)
//  DIGITS  4  number of 7-seg displays driven, sign position included (>=2)
// PORTS
//  clk     in   1           system clock, all state updates on posedge
//  rst_n   in   1           synchronous active-low reset
//  start   in   1           1-cycle request: convert bin; ignored while busy=1
//  bin     in   WIDTH       operand, sampled on the start cycle only
//  sgn     in   1           1: bin is two's complement, 0: unsigned; sampled with bin
//  enable  in   1           0: blank all displays (combinational); conversion unaffected
//  segs    out  7*DIGITS    segs[7k+6:7k] = display k (k=0 least significant), active-low
//  busy    out  1           conversion in progress
//  done    out  1           1-cycle pulse: new result visible on segs/ovf
//  ovf     out  1           latched result does not fit in DIGITS positions
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, busy=0, done=0, ovf=0, every display 7'h7F.
//    Reset mid-conversion aborts it. No done is issued, and the display stays blank until
//    the next completed conversion.
//  - Encoding: bit6=g..bit0=a; 0=7'h40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=18;
//    minus=7'h3F; blank=7'h7F.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//    IDLE: start=1 latches sign=sgn&bin[WIDTH-1] and mag=|bin| (WIDTH-bit unsigned, so
//    -2^(WIDTH-1) gives 2^(WIDTH-1)). It clears the BCD register and carry flag, sets
//    busy=1, bitcnt=WIDTH-1 -> SHIFT.
//    SHIFT: each cycle, every BCD nibble >=5 gets +3, then {bcd,mag} shifts left one.
//    The bit leaving the top nibble ORs into a sticky carry flag. Leaves after WIDTH
//    shifts (bitcnt==0) -> DONE.
//    DONE: loads the display register, ovf, done=1 and busy=0 -> IDLE.
//  - Latency: start sampled at edge N gives busy=1 on edges N+1..N+WIDTH+1. done=1 and
//    segs update for the cycle after edge N+WIDTH+1. Back-to-back: start may be accepted
//    in the cycle done is high.
//  - start while busy=1 is ignored: no queueing, bin/sgn changes have no effect.
//  - Display formatting (computed in DONE, held until next DONE):
//    * msd = highest nonzero BCD digit index; value 0 gives msd=0 and shows '0' on k=0.
//    * Digits above msd are blank. If sign=1, display msd+1 shows minus.
//    * ovf=1 if carry flag set, or if sign=1 and msd==DIGITS-1. Then all DIGITS show
//      minus, otherwise ovf=0.
//  - enable=0 forces segs to all 7'h7F. ovf/done/busy still operate. Re-enabling shows
//    the held result with no reconversion.
//  - sgn=0 treats bin[WIDTH-1] as magnitude; sign is never displayed.
//  - Internal BCD register is 4*DIGITS bits; counter width $clog2(WIDTH).
// TESTING (WIDTH=8, DIGITS=4 unless stated; display order H3..H0)
//  1. sgn=1 bin=8'h80, start pulse -> busy 9 cycles, done pulse, segs = 3F,79,24,00
//     ("-128"), ovf=0.
//  2. bin=8'h00 sgn=1 -> 7F,7F,7F,40; sgn=0 bin=8'hFF -> 7F,24,12,12 (" 255");
//     sgn=1 bin=8'hFB -> 7F,7F,3F,12 ("  -5").
//  3. DIGITS=2: sgn=0 bin=100 -> ovf=1, segs 3F,3F; sgn=1 bin=-9 -> 3F,18;
//     sgn=1 bin=-10 -> ovf=1.
//  4. start with bin=5, re-pulse start with bin=7 at cycle 3 -> single done, shows 5;
//     start in done cycle -> accepted.
//  5. rst_n=0 at SHIFT cycle 4 -> next cycle busy=0, all 7F, no done; new start converts
//     normally.
//  6. Hold result "-128", enable=0 -> all 7F, ovf unchanged; enable=1 -> "-128" restored
//     same cycle.

Source files
------------

// File: rtl/disp_signed_dec_seq.sv
// Sequential binary-to-decimal 7-segment display driver.
// Iterative shift-add-3 conversion (one operand bit per clock), optional
// two's complement input, leading-zero blanking, floating minus sign and
// overflow indication. Segment outputs are active-low, bit6=g .. bit0=a.
module disp_signed_dec_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  input  logic                  sgn_i,
  input  logic                  enable_i,
  output logic [7*DIGITS-1:0]   segs_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ovf_o
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CW   = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic [1:0]          state_q;
  logic                sign_q;
  logic [WIDTH-1:0]    mag_q;
  logic [BCDW-1:0]     bcd_q;
  logic                carry_q;
  logic [CW-1:0]       bitcnt_q;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;
  logic [7*DIGITS-1:0] disp_q;

  logic                neg_s;
  logic [BCDW-1:0]     bcd_adj_s;
  logic [BCDW-1:0]     bcd_shift_s;
  logic [WIDTH-1:0]    mag_shift_s;
  logic [DIGITS-1:0]   nz_s;
  logic [DIGITS-1:0]   show_s;
  logic [DIGITS-1:0]   show_prev_s;
  logic                acc_s;
  logic                ovf_fmt_s;
  logic [7*DIGITS-1:0] disp_fmt_s;

  // Seven-segment glyph for one BCD digit (active-low).
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h18;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCDW-1:0] add3(input logic [BCDW-1:0] b);
    logic [BCDW-1:0] r;
    for (int k = 0; k < DIGITS; k++) begin
      if (b[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = b[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = b[4*k +: 4];
      end
    end
    return r;
  endfunction

  // Operand sign/magnitude split and one shift-add-3 step of the engine.
  always_comb begin
    neg_s       = sgn_i & bin_i[WIDTH-1];
    bcd_adj_s   = add3(bcd_q);
    bcd_shift_s = {bcd_adj_s[BCDW-2:0], mag_q[WIDTH-1]};
    mag_shift_s = {mag_q[WIDTH-2:0], 1'b0};
  end

  // Result formatting: blank above the top nonzero digit, floating minus, overflow.
  always_comb begin
    acc_s      = 1'b0;
    nz_s       = '0;
    show_s     = '0;
    disp_fmt_s = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz_s[k]   = |bcd_q[4*k +: 4];
      acc_s     = acc_s | nz_s[k];
      show_s[k] = acc_s;
    end
    // Digit 0 is always shown so a zero result reads '0'.
    show_s[0]   = 1'b1;
    show_prev_s = {show_s[DIGITS-2:0], 1'b0};
    ovf_fmt_s   = carry_q | (sign_q & nz_s[DIGITS-1]);
    for (int k = 0; k < DIGITS; k++) begin
      if (ovf_fmt_s) begin
        disp_fmt_s[7*k +: 7] = SEG_MINUS;
      end else if (show_s[k]) begin
        disp_fmt_s[7*k +: 7] = seg_enc(bcd_q[4*k +: 4]);
      end else if (sign_q && show_prev_s[k]) begin
        disp_fmt_s[7*k +: 7] = SEG_MINUS;
      end else begin
        disp_fmt_s[7*k +: 7] = SEG_BLANK;
      end
    end
  end

  // Conversion FSM and held display/status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      bcd_q    <= '0;
      carry_q  <= 1'b0;
      bitcnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      disp_q   <= '1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            sign_q   <= neg_s;
            mag_q    <= neg_s ? (~bin_i + {{(WIDTH-1){1'b0}}, 1'b1}) : bin_i;
            bcd_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b1;
            bitcnt_q <= CW'(WIDTH - 1);
            state_q  <= ST_SHIFT;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          bcd_q    <= bcd_shift_s;
          mag_q    <= mag_shift_s;
          carry_q  <= carry_q | bcd_adj_s[BCDW-1];
          bitcnt_q <= bitcnt_q - CW'(1);
          if (bitcnt_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          disp_q  <= disp_fmt_s;
          ovf_q   <= ovf_fmt_s;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Display enable gates the held result without touching it.
  always_comb begin
    if (enable_i) begin
      segs_o = disp_q;
    end else begin
      segs_o = '1;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_disp_signed_dec_seq.sv
// Bench for disp_signed_dec_seq: a 4-digit and a 2-digit instance share the
// same stimulus; expected results are queued at start and checked at done.
module tb_disp_signed_dec_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin;
  logic        sgn;
  logic        enable;
  logic [27:0] segs4;
  logic        busy4, done4, ovf4;
  logic [13:0] segs2;
  logic        busy2, done2, ovf2;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0]  bin;
    logic        sgn;
    logic [27:0] s4;
    logic        o4;
    logic [13:0] s2;
    logic        o2;
  } vec_t;

  vec_t vecs[13];
  vec_t sb[$];

  disp_signed_dec_seq #(.WIDTH(8), .DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .bin_i(bin), .sgn_i(sgn),
    .enable_i(enable), .segs_o(segs4), .busy_o(busy4), .done_o(done4), .ovf_o(ovf4)
  );

  disp_signed_dec_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .bin_i(bin), .sgn_i(sgn),
    .enable_i(enable), .segs_o(segs2), .busy_o(busy2), .done_o(done2), .ovf_o(ovf2)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_conv(input vec_t v);
    sb.push_back(v);
    bin   = v.bin;
    sgn   = v.sgn;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit chk_busy);
    int   cnt;
    bit   seen;
    vec_t e;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done4) begin
        seen = 1'b1;
        break;
      end
      if (busy4) cnt++;
      tick();
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      check("busy_at_done", {31'd0, busy4}, 32'd0);
      check("done2_at_done", {31'd0, done2}, 32'd1);
      if (chk_busy) check("busy_cycles", cnt, 32'd9);
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check("segs4", {4'd0, segs4}, {4'd0, e.s4});
        check("ovf4", {31'd0, ovf4}, {31'd0, e.o4});
        check("segs2", {18'd0, segs2}, {18'd0, e.s2});
        check("ovf2", {31'd0, ovf2}, {31'd0, e.o2});
      end
    end
  endtask

  initial begin
    int dcnt;
    vecs[0]  = '{8'h80, 1'b1, {7'h3F, 7'h79, 7'h24, 7'h00}, 1'b0, {7'h3F, 7'h3F}, 1'b1};
    vecs[1]  = '{8'h00, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0, {7'h7F, 7'h40}, 1'b0};
    vecs[2]  = '{8'hFF, 1'b0, {7'h7F, 7'h24, 7'h12, 7'h12}, 1'b0, {7'h3F, 7'h3F}, 1'b1};
    vecs[3]  = '{8'hFB, 1'b1, {7'h7F, 7'h7F, 7'h3F, 7'h12}, 1'b0, {7'h3F, 7'h12}, 1'b0};
    vecs[4]  = '{8'hFF, 1'b1, {7'h7F, 7'h7F, 7'h3F, 7'h79}, 1'b0, {7'h3F, 7'h79}, 1'b0};
    vecs[5]  = '{8'h7F, 1'b1, {7'h7F, 7'h79, 7'h24, 7'h78}, 1'b0, {7'h3F, 7'h3F}, 1'b1};
    vecs[6]  = '{8'h0A, 1'b0, {7'h7F, 7'h7F, 7'h79, 7'h40}, 1'b0, {7'h79, 7'h40}, 1'b0};
    vecs[7]  = '{8'h9C, 1'b1, {7'h3F, 7'h79, 7'h40, 7'h40}, 1'b0, {7'h3F, 7'h3F}, 1'b1};
    vecs[8]  = '{8'h64, 1'b0, {7'h7F, 7'h79, 7'h40, 7'h40}, 1'b0, {7'h3F, 7'h3F}, 1'b1};
    vecs[9]  = '{8'hF7, 1'b1, {7'h7F, 7'h7F, 7'h3F, 7'h18}, 1'b0, {7'h3F, 7'h18}, 1'b0};
    vecs[10] = '{8'hF6, 1'b1, {7'h7F, 7'h3F, 7'h79, 7'h40}, 1'b0, {7'h3F, 7'h3F}, 1'b1};
    vecs[11] = '{8'h63, 1'b0, {7'h7F, 7'h7F, 7'h18, 7'h18}, 1'b0, {7'h18, 7'h18}, 1'b0};
    vecs[12] = '{8'h05, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 1'b0, {7'h7F, 7'h12}, 1'b0};

    rst_n  = 1'b0;
    start  = 1'b0;
    bin    = 8'h00;
    sgn    = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    check("rst_busy", {31'd0, busy4}, 32'd0);
    check("rst_done", {31'd0, done4}, 32'd0);
    check("rst_ovf", {31'd0, ovf4}, 32'd0);
    check("rst_segs4", {4'd0, segs4}, {4'd0, 28'hFFFFFFF});
    check("rst_segs2", {18'd0, segs2}, {18'd0, 14'h3FFF});
    rst_n = 1'b1;
    tick();

    // Table sweep; each new start lands in the previous done cycle.
    for (int i = 0; i < 13; i++) begin
      start_conv(vecs[i]);
      wait_done(1'b1);
    end
    tick();

    // Re-pulsed start while busy is ignored: one done, first operand shown.
    start_conv(vecs[12]);
    tick();
    tick();
    bin   = 8'h07;
    sgn   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0);
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done4) dcnt++;
    end
    check("no_extra_done", dcnt, 32'd0);
    check("held_after_ignore", {4'd0, segs4}, {4'd0, vecs[12].s4});

    // Reset in the middle of SHIFT aborts with a blank display and no done.
    start_conv(vecs[0]);
    sb.delete();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", {31'd0, busy4}, 32'd0);
    check("abort_done", {31'd0, done4}, 32'd0);
    check("abort_segs4", {4'd0, segs4}, {4'd0, 28'hFFFFFFF});
    check("abort_segs2", {18'd0, segs2}, {18'd0, 14'h3FFF});
    dcnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done4 || done2) dcnt++;
    end
    check("abort_no_done", dcnt, 32'd0);
    check("abort_still_blank", {4'd0, segs4}, {4'd0, 28'hFFFFFFF});
    start_conv(vecs[3]);
    wait_done(1'b1);

    // Enable gating of a held "-128".
    start_conv(vecs[0]);
    wait_done(1'b1);
    tick();
    enable = 1'b0;
    #1;
    check("en0_segs4", {4'd0, segs4}, {4'd0, 28'hFFFFFFF});
    check("en0_segs2", {18'd0, segs2}, {18'd0, 14'h3FFF});
    check("en0_ovf4", {31'd0, ovf4}, 32'd0);
    check("en0_ovf2", {31'd0, ovf2}, 32'd1);
    tick();
    check("en0_hold", {4'd0, segs4}, {4'd0, 28'hFFFFFFF});
    enable = 1'b1;
    #1;
    check("en1_segs4", {4'd0, segs4}, {4'd0, vecs[0].s4});
    check("en1_segs2", {18'd0, segs2}, {18'd0, vecs[0].s2});
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
